// File: rtl/psub_seq_if.sv
// Handshake and operand/result bundle for the sequential packed sub-word subtractor.
// master drives the request side; slave is the functional unit.
interface psub_seq_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Diff;
  logic [3:0]  Lane_ovfl;
  logic        Error;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Lane_ovfl, Error
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Lane_ovfl, Error
  );
endinterface

// File: rtl/psub_seq.sv
// Sequential packed sub-word subtractor: four signed 4-bit lanes of A - B,
// one lane per cycle through a shared 4-bit datapath, optional saturation.
module psub_seq #(
  parameter bit SATURATE = 1'b1
) (
  input logic   clk,
  input logic   rst,
  psub_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic [15:0] r_work;
  logic [3:0]  r_flags;
  logic [1:0]  r_lane;
  logic [15:0] r_diff;
  logic [3:0]  r_lane_ovfl;
  logic        r_error;

  logic [3:0]  w_a;
  logic [3:0]  w_b;
  logic [3:0]  w_d;
  logic        w_ovf;
  logic [3:0]  w_res;
  logic [15:0] w_work_next;
  logic [3:0]  w_flags_next;
  logic        w_last_lane;

  // Shared lane datapath: subtract as a + ~b + 1, overflow from sign bits only.
  assign w_a   = r_op_a[{r_lane, 2'b00} +: 4];
  assign w_b   = r_op_b[{r_lane, 2'b00} +: 4];
  assign w_d   = w_a + ~w_b + 4'd1;
  assign w_ovf = (w_a[3] ^ w_b[3]) & (w_d[3] ^ w_a[3]);

  always_comb begin
    w_res = w_d;
    if (SATURATE && w_ovf) begin
      w_res = w_a[3] ? 4'h8 : 4'h7;
    end
  end

  always_comb begin
    w_work_next                          = r_work;
    w_work_next[{r_lane, 2'b00} +: 4]    = w_res;
    w_flags_next                         = r_flags;
    w_flags_next[r_lane]                 = w_ovf;
  end

  assign w_last_lane = (r_lane == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = StRun;
      StRun:   if (w_last_lane) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StRun:   bus.busy = 1'b1;
      StDone: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Diff      = r_diff;
  assign bus.Lane_ovfl = r_lane_ovfl;
  assign bus.Error     = r_error;

  // Datapath registers; result registers load only on the RUN->DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a      <= 16'h0000;
      r_op_b      <= 16'h0000;
      r_work      <= 16'h0000;
      r_flags     <= 4'h0;
      r_lane      <= 2'd0;
      r_diff      <= 16'h0000;
      r_lane_ovfl <= 4'h0;
      r_error     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_op_a  <= bus.A;
            r_op_b  <= bus.B;
            r_work  <= 16'h0000;
            r_flags <= 4'h0;
            r_lane  <= 2'd0;
          end
        end
        StRun: begin
          r_work  <= w_work_next;
          r_flags <= w_flags_next;
          r_lane  <= r_lane + 2'd1;
          if (w_last_lane) begin
            r_diff      <= w_work_next;
            r_lane_ovfl <= w_flags_next;
            r_error     <= |w_flags_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psub_seq.sv
// Scoreboard bench for psub_seq: saturating and wrapping instances share stimulus;
// a cycle model predicts acceptance, results and done timing.
module tb_psub_seq;

  typedef struct {
    logic [15:0] diff;
    logic [3:0]  ovfl;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        s_start = 1'b0;
  logic [15:0] s_a = 16'h0000;
  logic [15:0] s_b = 16'h0000;
  logic        rst_q = 1'b1;
  int          cyc = 0;
  int          m_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  exp_t        q[2][$];
  logic [15:0] last_diff[2];
  logic [3:0]  last_ovfl[2];

  logic        w_busy[2];
  logic        w_done[2];
  logic [15:0] w_diff[2];
  logic [3:0]  w_ovfl[2];
  logic        w_err[2];

  psub_seq_if if_sat ();
  psub_seq_if if_wrap ();

  assign if_sat.start  = s_start;
  assign if_sat.A      = s_a;
  assign if_sat.B      = s_b;
  assign if_wrap.start = s_start;
  assign if_wrap.A     = s_a;
  assign if_wrap.B     = s_b;

  assign w_busy[0] = if_sat.busy;
  assign w_done[0] = if_sat.done;
  assign w_diff[0] = if_sat.Diff;
  assign w_ovfl[0] = if_sat.Lane_ovfl;
  assign w_err[0]  = if_sat.Error;
  assign w_busy[1] = if_wrap.busy;
  assign w_done[1] = if_wrap.done;
  assign w_diff[1] = if_wrap.Diff;
  assign w_ovfl[1] = if_wrap.Lane_ovfl;
  assign w_err[1]  = if_wrap.Error;

  psub_seq #(.SATURATE(1'b1)) u_sat (
    .clk (clk),
    .rst (s_rst),
    .bus (if_sat)
  );

  psub_seq #(.SATURATE(1'b0)) u_wrap (
    .clk (clk),
    .rst (s_rst),
    .bus (if_wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: integer lane difference, then clamp or wrap.
  function automatic logic [19:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input bit sat);
    logic [15:0] d;
    logic [3:0]  o;
    int          x;
    int          y;
    int          r;
    for (int k = 0; k < 4; k++) begin
      x = int'($signed(a[k*4 +: 4]));
      y = int'($signed(b[k*4 +: 4]));
      r = x - y;
      o[k] = (r > 7) || (r < -8);
      if (o[k] && sat) d[k*4 +: 4] = (r > 7) ? 4'h7 : 4'h8;
      else             d[k*4 +: 4] = 4'(r);
    end
    return {o, d};
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= s_rst;
  end

  // Acceptance model: 4 RUN + 1 DONE cycles after an accepted start.
  always @(posedge clk) begin
    logic [19:0] r0;
    logic [19:0] r1;
    exp_t        e;
    if (s_rst) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (s_start) begin
        m_cnt <= 5;
        r0 = ref_sub(s_a, s_b, 1'b1);
        r1 = ref_sub(s_a, s_b, 1'b0);
        e.cyc  = cyc + 5;
        e.diff = r0[15:0];
        e.ovfl = r0[19:16];
        q[0].push_back(e);
        e.diff = r1[15:0];
        e.ovfl = r1[19:16];
        q[1].push_back(e);
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst_q) begin
        last_diff[k] = 16'h0000;
        last_ovfl[k] = 4'h0;
        check_eq("rst_busy", 32'(w_busy[k]), 32'd0);
        check_eq("rst_done", 32'(w_done[k]), 32'd0);
        check_eq("rst_diff", 32'(w_diff[k]), 32'd0);
        check_eq("rst_ovfl", 32'(w_ovfl[k]), 32'd0);
        check_eq("rst_err", 32'(w_err[k]), 32'd0);
      end else begin
        check_eq("busy", 32'(w_busy[k]), 32'(m_cnt != 0));
        check_eq("done", 32'(w_done[k]), 32'(m_cnt == 1));
        if (w_done[k]) begin
          if (q[k].size() == 0) begin
            check_eq("spurious_done", 32'd1, 32'd0);
          end else begin
            e = q[k].pop_front();
            last_diff[k] = e.diff;
            last_ovfl[k] = e.ovfl;
            check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        check_eq(k == 0 ? "diff_sat" : "diff_wrap", 32'(w_diff[k]), 32'(last_diff[k]));
        check_eq("lane_ovfl", 32'(w_ovfl[k]), 32'(last_ovfl[k]));
        check_eq("error", 32'(w_err[k]), 32'(|last_ovfl[k]));
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    s_rst   = 1'b1;
    s_start = 1'b0;
    q[0].delete();
    q[1].delete();
    repeat (n) @(negedge clk);
    s_rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (w_done[0]) seen = 1'b1;
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_directed(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] d_sat, input logic [15:0] d_wrap,
                              input logic [3:0] ovfl);
    @(negedge clk);
    s_a     = a;
    s_b     = b;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_a     = ~a;
    s_b     = ~b;
    wait_done(20);
    check_eq("dir_diff_sat", 32'(w_diff[0]), 32'(d_sat));
    check_eq("dir_diff_wrap", 32'(w_diff[1]), 32'(d_wrap));
    check_eq("dir_ovfl_sat", 32'(w_ovfl[0]), 32'(ovfl));
    check_eq("dir_ovfl_wrap", 32'(w_ovfl[1]), 32'(ovfl));
    check_eq("dir_err", 32'(w_err[0]), 32'(|ovfl));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    do_reset(3);
    repeat (2) @(negedge clk);

    run_directed(16'h1234, 16'h0111, 16'h1123, 16'h1123, 4'b0000);
    run_directed(16'h7000, 16'h8000, 16'h7000, 16'hF000, 4'b1000);
    run_directed(16'h0008, 16'h0001, 16'h0008, 16'h0007, 4'b0001);

    // start held high with operands changing every cycle
    @(negedge clk);
    s_start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      s_a = 16'($urandom);
      s_b = 16'($urandom);
      @(negedge clk);
    end
    s_start = 1'b0;
    repeat (8) @(negedge clk);

    // start pulses inside RUN and DONE must be ignored
    s_a = 16'h5A3C;
    s_b = 16'hC3A5;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (2) @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (6) @(negedge clk);

    // reset in the middle of an operation, then a clean operation
    s_a = 16'h7777;
    s_b = 16'h8888;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    do_reset(1);
    repeat (8) @(negedge clk);
    run_directed(16'h1234, 16'h0111, 16'h1123, 16'h1123, 4'b0000);

    // randomized sweep, ~1000 operations
    s_start = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      s_a = 16'($urandom);
      s_b = 16'($urandom);
      @(negedge clk);
    end
    s_start = 1'b0;
    repeat (10) @(negedge clk);

    check_eq("queue_drain_sat", 32'(q[0].size()), 32'd0);
    check_eq("queue_drain_wrap", 32'(q[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
